// File: rtl/adc_avg_pkg.sv
// Shared types and helpers for the ADC block averager.
// Build option ADC_AVG_OFFSET_BINARY_EN selects offset-binary (signed) samples instead of unsigned.
package adc_avg_pkg;

  localparam int DATA_W_DEF = 14;
  localparam int LOG2_N_DEF = 4;
  localparam int CNT_W_DEF  = 32;
  localparam int EXT_W      = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  // Widens a width-bit sample to EXT_W bits in the accumulator's number domain.
  function automatic logic [EXT_W-1:0] ext_sample(input logic [EXT_W-1:0] raw, input int width);
    logic [EXT_W-1:0] aligned;
    aligned = raw << (EXT_W - width);
`ifdef ADC_AVG_OFFSET_BINARY_EN
    // Offset binary to two's complement is an MSB flip; the arithmetic shift then sign-extends.
    aligned[EXT_W-1] = ~aligned[EXT_W-1];
    return EXT_W'($signed(aligned) >>> (EXT_W - width));
`else
    return aligned >> (EXT_W - width);
`endif
  endfunction

endpackage

// File: rtl/adc_avg_channel.sv
// One channel of the block averager: window accumulator plus held sum/mean output registers.
// Number domain follows ADC_AVG_OFFSET_BINARY_EN through adc_avg_pkg::ext_sample.
module adc_avg_channel
  import adc_avg_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LOG2_N = LOG2_N_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     accept,
  input  logic                     first,
  input  logic                     complete,
  input  logic [DATA_W-1:0]        sample,
  output logic [DATA_W+LOG2_N-1:0] sum,
  output logic [DATA_W-1:0]        mean
);

  localparam int ACC_W = DATA_W + LOG2_N;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [ACC_W-1:0] sample_ext;
  logic [ACC_W-1:0] acc_next;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    acc_d      = acc_q;
    sum_d      = sum_q;
    sample_ext = ACC_W'(ext_sample(EXT_W'(sample), DATA_W));
    acc_next   = (first ? '0 : acc_q) + sample_ext;
    if (clear) begin
      acc_d = '0;
    end else if (accept) begin
      acc_d = complete ? '0 : acc_next;
      if (complete) sum_d = acc_next;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: flops use non-blocking assignment so every register samples pre-edge values.
    if (reset) begin
      acc_q <= '0;
      sum_q <= '0;
    end else begin
      acc_q <= acc_d;
      sum_q <= sum_d;
    end
  end

  // Dropping the low LOG2_N bits is a floor divide by N in both number domains.
  assign sum  = sum_q;
  assign mean = sum_q[ACC_W-1:LOG2_N];

endmodule

// File: rtl/adc_block_averager.sv
// Decimating block averager: sums N = 2^LOG2_N valid samples per channel, emits sum and mean per window.
// Define ADC_AVG_OFFSET_BINARY_EN for offset-binary inputs with signed sums/means.
module adc_block_averager
  import adc_avg_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LOG2_N = LOG2_N_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                     CLK_65,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [DATA_W-1:0]        data_canal_a_in,
  input  logic [DATA_W-1:0]        data_canal_b_in,
  input  logic                     data_valid_in,
  output logic [DATA_W+LOG2_N-1:0] sum_a,
  output logic [DATA_W+LOG2_N-1:0] sum_b,
  output logic [DATA_W-1:0]        mean_a,
  output logic [DATA_W-1:0]        mean_b,
  output logic                     out_valid,
  output logic [CNT_W-1:0]         window_count,
  output logic                     busy
);

  localparam logic [LOG2_N:0] LAST_CNT = (LOG2_N + 1)'((1 << LOG2_N) - 1);
  localparam logic [LOG2_N:0] CNT_ONE  = (LOG2_N + 1)'(1);
  localparam bit              SINGLE   = (LOG2_N == 0);

  state_e            state_q, state_d;
  logic [LOG2_N:0]   cnt_q, cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [CNT_W-1:0]  window_count_q, window_count_d;

  logic accept;
  logic ch_clear;
  logic ch_first;
  logic ch_complete;

  always_ff @(posedge CLK_65) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      out_valid_q    <= 1'b0;
      window_count_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      out_valid_q    <= out_valid_d;
      window_count_q <= window_count_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    out_valid_d    = ch_complete;
    window_count_d = window_count_q + CNT_W'(ch_complete);
    case (state_q)
      IDLE: begin
        // A one-sample window completes straight from IDLE and never enters ACCUM.
        if (accept && !SINGLE) begin
          state_d = ACCUM;
          cnt_d   = CNT_ONE;
        end
      end
      ACCUM: begin
        if (!enable) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (accept) begin
          cnt_d = ch_complete ? '0 : cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    accept      = enable && data_valid_in;
    ch_first    = (state_q == IDLE);
    ch_clear    = (state_q == ACCUM) && !enable;
    ch_complete = 1'b0;
    if (accept) ch_complete = (state_q == IDLE) ? SINGLE : (cnt_q == LAST_CNT);
    busy        = (state_q == ACCUM);
  end

  adc_avg_channel #(.DATA_W(DATA_W), .LOG2_N(LOG2_N)) u_chan_a (
    .clk      (CLK_65),
    .reset    (reset),
    .clear    (ch_clear),
    .accept   (accept),
    .first    (ch_first),
    .complete (ch_complete),
    .sample   (data_canal_a_in),
    .sum      (sum_a),
    .mean     (mean_a)
  );

  adc_avg_channel #(.DATA_W(DATA_W), .LOG2_N(LOG2_N)) u_chan_b (
    .clk      (CLK_65),
    .reset    (reset),
    .clear    (ch_clear),
    .accept   (accept),
    .first    (ch_first),
    .complete (ch_complete),
    .sample   (data_canal_b_in),
    .sum      (sum_b),
    .mean     (mean_b)
  );

  assign out_valid    = out_valid_q;
  assign window_count = window_count_q;

endmodule

// File: tb/tb_adc_block_averager.sv
// Bench for adc_block_averager: three configurations (N=4, N=2, N=1 with 4-bit window counter) share one
// input stream and are compared every cycle against a window-sum model, plus directed scenario checks.
module tb_adc_block_averager;

  localparam int DW = 14;
  localparam int L_TAB  [3] = '{2, 1, 0};
  localparam int CW_TAB [3] = '{32, 32, 4};
`ifdef ADC_AVG_OFFSET_BINARY_EN
  localparam int OFFSET = 8192;
`else
  localparam int OFFSET = 0;
`endif

  logic clk = 1'b0;
  always #7 clk = ~clk;

  logic          reset, enable, valid;
  logic [DW-1:0] a, b;

  logic [15:0] sum_a_0, sum_b_0;
  logic [13:0] mean_a_0, mean_b_0;
  logic        ov_0, busy_0;
  logic [31:0] wc_0;
  logic [14:0] sum_a_1, sum_b_1;
  logic [13:0] mean_a_1, mean_b_1;
  logic        ov_1, busy_1;
  logic [31:0] wc_1;
  logic [13:0] sum_a_2, sum_b_2;
  logic [13:0] mean_a_2, mean_b_2;
  logic        ov_2, busy_2;
  logic [3:0]  wc_2;

  adc_block_averager #(.DATA_W(DW), .LOG2_N(2), .CNT_W(32)) dut0 (
    .CLK_65(clk), .reset(reset), .enable(enable), .data_canal_a_in(a), .data_canal_b_in(b),
    .data_valid_in(valid), .sum_a(sum_a_0), .sum_b(sum_b_0), .mean_a(mean_a_0), .mean_b(mean_b_0),
    .out_valid(ov_0), .window_count(wc_0), .busy(busy_0));

  adc_block_averager #(.DATA_W(DW), .LOG2_N(1), .CNT_W(32)) dut1 (
    .CLK_65(clk), .reset(reset), .enable(enable), .data_canal_a_in(a), .data_canal_b_in(b),
    .data_valid_in(valid), .sum_a(sum_a_1), .sum_b(sum_b_1), .mean_a(mean_a_1), .mean_b(mean_b_1),
    .out_valid(ov_1), .window_count(wc_1), .busy(busy_1));

  adc_block_averager #(.DATA_W(DW), .LOG2_N(0), .CNT_W(4)) dut2 (
    .CLK_65(clk), .reset(reset), .enable(enable), .data_canal_a_in(a), .data_canal_b_in(b),
    .data_valid_in(valid), .sum_a(sum_a_2), .sum_b(sum_b_2), .mean_a(mean_a_2), .mean_b(mean_b_2),
    .out_valid(ov_2), .window_count(wc_2), .busy(busy_2));

  logic [31:0] got_sum_a [3], got_sum_b [3], got_mean_a [3], got_mean_b [3];
  logic [31:0] got_ov [3], got_busy [3], got_wc [3];
  assign got_sum_a[0]  = 32'(sum_a_0);  assign got_sum_a[1]  = 32'(sum_a_1);  assign got_sum_a[2]  = 32'(sum_a_2);
  assign got_sum_b[0]  = 32'(sum_b_0);  assign got_sum_b[1]  = 32'(sum_b_1);  assign got_sum_b[2]  = 32'(sum_b_2);
  assign got_mean_a[0] = 32'(mean_a_0); assign got_mean_a[1] = 32'(mean_a_1); assign got_mean_a[2] = 32'(mean_a_2);
  assign got_mean_b[0] = 32'(mean_b_0); assign got_mean_b[1] = 32'(mean_b_1); assign got_mean_b[2] = 32'(mean_b_2);
  assign got_ov[0]     = 32'(ov_0);     assign got_ov[1]     = 32'(ov_1);     assign got_ov[2]     = 32'(ov_2);
  assign got_busy[0]   = 32'(busy_0);   assign got_busy[1]   = 32'(busy_1);   assign got_busy[2]   = 32'(busy_2);
  assign got_wc[0]     = wc_0;          assign got_wc[1]     = wc_1;          assign got_wc[2]     = 32'(wc_2);

  int checks = 0;
  int failures = 0;

  // Window model: running per-window sums in signed integer arithmetic.
  int     win_sum_a [3], win_sum_b [3], win_cnt [3];
  int     exp_sum_a [3], exp_sum_b [3];
  bit     exp_valid [3], exp_busy [3];
  longint exp_wc [3];

  function automatic logic [31:0] mask_w(input int w);
    return 32'((64'd1 << w) - 64'd1);
  endfunction

  task automatic model_clear(input int k);
    win_sum_a[k] = 0; win_sum_b[k] = 0; win_cnt[k] = 0;
  endtask

  task automatic tick();
    string       nm;
    logic [31:0] g, e;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        model_clear(k);
        exp_sum_a[k] = 0; exp_sum_b[k] = 0; exp_valid[k] = 0; exp_busy[k] = 0; exp_wc[k] = 0;
      end else begin
        exp_valid[k] = 0;
        if (!enable) begin
          model_clear(k);
          exp_busy[k] = 0;
        end else if (valid) begin
          win_sum_a[k] += int'(a) - OFFSET;
          win_sum_b[k] += int'(b) - OFFSET;
          win_cnt[k]++;
          if (L_TAB[k] > 0) exp_busy[k] = 1;
          if (win_cnt[k] == (1 << L_TAB[k])) begin
            exp_sum_a[k] = win_sum_a[k];
            exp_sum_b[k] = win_sum_b[k];
            exp_valid[k] = 1;
            exp_wc[k]    = (exp_wc[k] + 1) & ((64'd1 << CW_TAB[k]) - 1);
            model_clear(k);
          end
        end
      end
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 7; j++) begin
        case (j)
          0: begin nm = "out_valid"; g = got_ov[k];     e = 32'(exp_valid[k]); end
          1: begin nm = "busy";      g = got_busy[k];   e = 32'(exp_busy[k]); end
          2: begin nm = "win_count"; g = got_wc[k];     e = 32'(exp_wc[k]); end
          3: begin nm = "sum_a";     g = got_sum_a[k];  e = 32'(exp_sum_a[k]) & mask_w(DW + L_TAB[k]); end
          4: begin nm = "sum_b";     g = got_sum_b[k];  e = 32'(exp_sum_b[k]) & mask_w(DW + L_TAB[k]); end
          5: begin nm = "mean_a";    g = got_mean_a[k]; e = 32'(exp_sum_a[k] >>> L_TAB[k]) & mask_w(DW); end
          default: begin nm = "mean_b"; g = got_mean_b[k]; e = 32'(exp_sum_b[k] >>> L_TAB[k]) & mask_w(DW); end
        endcase
        checks++;
        if (g !== e) begin
          failures++;
          $display("FAIL model_%s inst%0d t=%0t got=%0h exp=%0h", nm, k, $time, g, e);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1; enable = 0; valid = 0; a = '0; b = '0;
    repeat (3) tick();
    checks++; if (ov_0 !== 1'b0)  begin failures++; $display("FAIL reset_out_valid got=%0h exp=0", ov_0); end
    checks++; if (sum_a_0 !== '0) begin failures++; $display("FAIL reset_sum_a got=%0h exp=0", sum_a_0); end
    checks++; if (wc_0 !== '0)    begin failures++; $display("FAIL reset_win_count got=%0h exp=0", wc_0); end
    checks++; if (busy_0 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0h exp=0", busy_0); end
    reset = 0;
  endtask

  task automatic test_basic_window();
    enable = 1; valid = 1; b = 14'd5;
    for (int i = 0; i < 4; i++) begin
      a = 14'(100 + i);
      tick();
    end
    checks++; if (ov_0 !== 1'b1) begin failures++; $display("FAIL basic_out_valid got=%0h exp=1", ov_0); end
    checks++; if (wc_0 !== 32'd1) begin failures++; $display("FAIL basic_win_count got=%0d exp=1", wc_0); end
`ifndef ADC_AVG_OFFSET_BINARY_EN
    checks++; if (sum_a_0 !== 16'd406)  begin failures++; $display("FAIL basic_sum_a got=%0d exp=406", sum_a_0); end
    checks++; if (mean_a_0 !== 14'd101) begin failures++; $display("FAIL basic_mean_a got=%0d exp=101", mean_a_0); end
    checks++; if (sum_b_0 !== 16'd20)   begin failures++; $display("FAIL basic_sum_b got=%0d exp=20", sum_b_0); end
    checks++; if (mean_b_0 !== 14'd5)   begin failures++; $display("FAIL basic_mean_b got=%0d exp=5", mean_b_0); end
`endif
    valid = 0;
    tick();
    checks++; if (ov_0 !== 1'b0) begin failures++; $display("FAIL basic_pulse_width got=%0h exp=0", ov_0); end
`ifndef ADC_AVG_OFFSET_BINARY_EN
    checks++; if (sum_a_0 !== 16'd406) begin failures++; $display("FAIL basic_sum_hold got=%0d exp=406", sum_a_0); end
`endif
  endtask

  task automatic test_valid_gaps();
    int accepted = 0;
    int pulses = 0;
    enable = 1; a = 14'd1000; b = 14'($urandom);
    for (int cyc = 0; cyc < 16; cyc++) begin
      valid = (cyc % 2 == 0);
      tick();
      if (valid) accepted++;
      if (ov_0) begin
        pulses++;
        checks++;
        if (!valid || (accepted % 4) != 0) begin
          failures++;
          $display("FAIL gaps_pulse_timing accepted=%0d valid=%0b exp=pulse only after 4th/8th", accepted, valid);
        end
      end
    end
    checks++; if (pulses !== 2) begin failures++; $display("FAIL gaps_pulse_count got=%0d exp=2", pulses); end
`ifndef ADC_AVG_OFFSET_BINARY_EN
    checks++; if (sum_a_0 !== 16'd4000) begin failures++; $display("FAIL gaps_sum_a got=%0d exp=4000", sum_a_0); end
`endif
  endtask

  task automatic test_enable_abort();
    int pulses = 0;
    enable = 1; valid = 1; a = 14'd10; b = 14'd10;
    repeat (3) begin tick(); if (ov_0) pulses++; end
    enable = 0; valid = 0;
    tick();
    if (ov_0) pulses++;
    checks++; if (busy_0 !== 1'b0) begin failures++; $display("FAIL abort_busy got=%0h exp=0", busy_0); end
    enable = 1; valid = 1;
    repeat (4) begin tick(); if (ov_0) pulses++; end
    checks++; if (pulses !== 1) begin failures++; $display("FAIL abort_pulse_count got=%0d exp=1", pulses); end
`ifndef ADC_AVG_OFFSET_BINARY_EN
    checks++; if (sum_a_0 !== 16'd40) begin failures++; $display("FAIL abort_sum_a got=%0d exp=40", sum_a_0); end
`endif
  endtask

  task automatic test_reset_mid_window();
    enable = 1; valid = 1; a = 14'd50; b = 14'd60;
    repeat (2) tick();
    reset = 1;
    tick();
    checks++; if (busy_0 !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%0h exp=0", busy_0); end
    checks++; if (sum_a_0 !== '0)  begin failures++; $display("FAIL rst_mid_sum_a got=%0h exp=0", sum_a_0); end
    checks++; if (wc_0 !== '0)     begin failures++; $display("FAIL rst_mid_win_count got=%0h exp=0", wc_0); end
    reset = 0;
    repeat (3) tick();
    checks++; if (busy_0 !== 1'b1) begin failures++; $display("FAIL rst_pre_busy got=%0h exp=1", busy_0); end
    reset = 1;
    tick();
    checks++; if (ov_0 !== 1'b0)   begin failures++; $display("FAIL rst_nth_out_valid got=%0h exp=0", ov_0); end
    checks++; if (sum_a_0 !== '0)  begin failures++; $display("FAIL rst_nth_sum_a got=%0h exp=0", sum_a_0); end
    checks++; if (mean_b_0 !== '0) begin failures++; $display("FAIL rst_nth_mean_b got=%0h exp=0", mean_b_0); end
    checks++; if (busy_0 !== 1'b0) begin failures++; $display("FAIL rst_nth_busy got=%0h exp=0", busy_0); end
    checks++; if (ov_2 !== 1'b0)   begin failures++; $display("FAIL rst_nth_out_valid_n1 got=%0h exp=0", ov_2); end
    reset = 0;
  endtask

  task automatic test_n1_and_wrap();
    reset = 1;
    tick();
    reset = 0; enable = 1; valid = 1; b = 14'd3;
    a = 14'd7;
    tick();
    checks++; if (ov_2 !== 1'b1) begin failures++; $display("FAIL n1_first_out_valid got=%0h exp=1", ov_2); end
    checks++; if (wc_2 !== 4'd1) begin failures++; $display("FAIL n1_first_win_count got=%0d exp=1", wc_2); end
`ifndef ADC_AVG_OFFSET_BINARY_EN
    checks++; if (sum_a_2 !== 14'd7)  begin failures++; $display("FAIL n1_sum_a_7 got=%0d exp=7", sum_a_2); end
    checks++; if (mean_a_2 !== 14'd7) begin failures++; $display("FAIL n1_mean_a_7 got=%0d exp=7", mean_a_2); end
`endif
    a = 14'd9;
    tick();
    checks++; if (ov_2 !== 1'b1) begin failures++; $display("FAIL n1_second_out_valid got=%0h exp=1", ov_2); end
`ifndef ADC_AVG_OFFSET_BINARY_EN
    checks++; if (sum_a_2 !== 14'd9)  begin failures++; $display("FAIL n1_sum_a_9 got=%0d exp=9", sum_a_2); end
    checks++; if (mean_a_2 !== 14'd9) begin failures++; $display("FAIL n1_mean_a_9 got=%0d exp=9", mean_a_2); end
`endif
    repeat (13) begin a = 14'($urandom); tick(); end
    checks++; if (wc_2 !== 4'd15) begin failures++; $display("FAIL wrap_before got=%0d exp=15", wc_2); end
    tick();
    checks++; if (wc_2 !== 4'd0) begin failures++; $display("FAIL wrap_after got=%0d exp=0", wc_2); end
    checks++; if (wc_0 !== 32'd4) begin failures++; $display("FAIL wrap_n4_win_count got=%0d exp=4", wc_0); end
  endtask

`ifdef ADC_AVG_OFFSET_BINARY_EN
  task automatic test_offset_binary();
    reset = 1;
    tick();
    reset = 0; enable = 1; valid = 1; b = 14'h2000;
    a = 14'h0000;
    tick();
    a = 14'h0001;
    tick();
    checks++; if (ov_1 !== 1'b1)        begin failures++; $display("FAIL signed_out_valid got=%0h exp=1", ov_1); end
    checks++; if (sum_a_1 !== 15'h4001) begin failures++; $display("FAIL signed_sum_a got=%0h exp=4001 (-16383)", sum_a_1); end
    checks++; if (mean_a_1 !== 14'h2000) begin failures++; $display("FAIL signed_mean_a got=%0h exp=2000 (-8192)", mean_a_1); end
    checks++; if (sum_b_1 !== 15'h0000) begin failures++; $display("FAIL signed_sum_b got=%0h exp=0", sum_b_1); end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      reset  = ($urandom_range(0, 63) == 0);
      enable = ($urandom_range(0, 15) != 0);
      valid  = ($urandom_range(0, 3) != 0);
      a      = 14'($urandom);
      b      = 14'($urandom);
      tick();
    end
    reset = 0;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      model_clear(k);
      exp_sum_a[k] = 0; exp_sum_b[k] = 0; exp_valid[k] = 0; exp_busy[k] = 0; exp_wc[k] = 0;
    end
    test_reset();
    test_basic_window();
    test_valid_gaps();
    test_enable_abort();
    test_reset_mid_window();
    test_n1_and_wrap();
`ifdef ADC_AVG_OFFSET_BINARY_EN
    test_offset_binary();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
